// File: rtl/txuart_fifo_if.sv
// Byte-stream interface for the FIFO-fronted UART transmitter: upstream
// valid/ready push channel plus the serial line and busy status.
interface txuart_fifo_if;
  logic [7:0] i_tx_byte;
  logic       i_tx_valid;
  logic       o_tx_ready;
  logic       o_uart_tx;
  logic       o_tx_busy;

  // Upstream producer side
  modport master (
    output i_tx_byte,
    output i_tx_valid,
    input  o_tx_ready,
    input  o_uart_tx,
    input  o_tx_busy
  );

  // Transmitter side
  modport slave (
    input  i_tx_byte,
    input  i_tx_valid,
    output o_tx_ready,
    output o_uart_tx,
    output o_tx_busy
  );
endinterface

// File: rtl/txuart_fifo.sv
// UART transmitter (8N1, LSB first) fed by a small power-of-two byte FIFO.
// Frames are back-to-back when the FIFO still holds data at the end of a stop bit.
module txuart_fifo #(
  parameter logic [31:0] CLOCK_RATE_HZ   = 32'd25_000_000,
  parameter logic [31:0] BAUD_RATE       = 32'd115_200,
  parameter logic [31:0] CLKS_PERBAUD    = CLOCK_RATE_HZ / BAUD_RATE,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  txuart_fifo_if.slave tx_if
);

  localparam int unsigned Depth  = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned PtrW   = FIFO_DEPTH_LOG2;
  localparam int unsigned CountW = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned CntW   = $clog2(CLKS_PERBAUD);
  localparam logic [CntW-1:0]   BaudLast  = CntW'(CLKS_PERBAUD - 32'd1);
  localparam logic [CountW-1:0] CountFull = CountW'(Depth);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // FIFO storage and bookkeeping
  logic [Depth-1:0][7:0] mem_q, mem_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0]     count_q, count_d;

  // Serialiser state
  state_e          state_q, state_d;
  logic [CntW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  logic tx_ready;
  logic push;
  logic pop;
  logic fifo_nonempty;
  logic baud_last;
  logic [7:0] head;

  // Ready depends only on registered occupancy, never on i_tx_valid
  assign tx_ready      = (count_q != CountFull);
  assign fifo_nonempty = (count_q != '0);
  assign push          = tx_if.i_tx_valid && tx_ready;
  assign baud_last     = (baud_cnt_q == BaudLast);
  assign head          = mem_q[rd_ptr_q];

  assign tx_if.o_tx_ready = tx_ready;
  assign tx_if.o_uart_tx  = tx_q;
  assign tx_if.o_tx_busy  = (state_q != StIdle) || fifo_nonempty;

  // FIFO next state: write on push, advance read on pop, occupancy tracks the difference
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = tx_if.i_tx_byte;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CountW'(1);
      2'b01:   count_d = count_q - CountW'(1);
      default: count_d = count_q;
    endcase
  end

  // Serialiser next state; the byte is latched into shift_q at pop time
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (fifo_nonempty) begin
          pop        = 1'b1;
          shift_d    = head;
          baud_cnt_d = '0;
          tx_d       = 1'b0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          tx_d       = shift_q[0];
          state_d    = StData;
        end else begin
          baud_cnt_d = baud_cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (fifo_nonempty) begin
            // Chain straight into the next start bit, no idle gap
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CntW'(1);
        end
      end
      default: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        state_d    = StIdle;
      end
    endcase
  end

  // State registers; reset aborts any frame and empties the FIFO
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

endmodule
